// File: rtl/telemetry_rcv_if.sv
`default_nettype none
// ============================================================================
//  Module   : telemetry_rcv_if
//  Purpose  : Serial line in, decoded telemetry fields and status pulses out,
//             for the eBike telemetry link receiver.
//  Revision : 1.0  initial release
// ============================================================================
interface telemetry_rcv_if;
  logic        RX;
  logic [11:0] batt_v;
  logic [11:0] avg_curr;
  logic [11:0] avg_torque;
  logic        vld;
  logic        frm_err;

  // Receiver side: consumes the serial line, produces the decoded packet
  modport master (
    input  RX,
    output batt_v,
    output avg_curr,
    output avg_torque,
    output vld,
    output frm_err
  );

  // Line driver / consumer side
  modport slave (
    output RX,
    input  batt_v,
    input  avg_curr,
    input  avg_torque,
    input  vld,
    input  frm_err
  );
endinterface
`default_nettype wire

// File: rtl/telemetry_rcv.sv
`default_nettype none
// ============================================================================
//  Module   : telemetry_rcv
//  Purpose  : UART receiver for the eBike telemetry link. Deserialises bytes
//             and reassembles 8-byte packets (AA 55 + six data bytes) into
//             batt_v, avg_curr and avg_torque.
//  Revision : 1.0  initial release
// ============================================================================
module telemetry_rcv #(
  parameter int BAUD_DIV = 2604
) (
  input  logic            clk,
  input  logic            rst_n,
  telemetry_rcv_if.master bus
);

  localparam int                CNT_W    = $clog2(BAUD_DIV) + 1;
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_st_t;
  typedef enum logic [1:0] {P_HDR1, P_HDR2, P_DATA} pkt_st_t;

  // RX synchroniser and edge history
  logic rx_meta_q, rx_s_q, rx_prev_q;

  // Byte deserialiser state
  byte_st_t         bst_q, bst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             baud_tick;
  logic             byte_rdy;
  logic             stop_err;

  // Packet assembler state
  pkt_st_t     pst_q, pst_d;
  logic [2:0]  pcnt_q, pcnt_d;
  logic [11:0] batt_st_q, batt_st_d;
  logic [11:0] curr_st_q, curr_st_d;
  logic [3:0]  tq_hi_q, tq_hi_d;
  logic [11:0] batt_v_q, batt_v_d;
  logic [11:0] avg_curr_q, avg_curr_d;
  logic [11:0] avg_torque_q, avg_torque_d;
  logic        vld_q, vld_d;
  logic        frm_err_q, frm_err_d;
  logic [7:0]  rx_byte;

  // Two-flop synchroniser plus one history flop for falling-edge detection;
  // all preset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Byte FSM: start-edge detect, mid-bit sampling, stop-bit check
  always_comb begin
    bst_d     = bst_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_rdy  = 1'b0;
    stop_err  = 1'b0;
    baud_tick = (cnt_q == CNT_ONE);
    case (bst_q)
      B_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          bst_d = B_START;
          cnt_d = CNT_HALF;
        end
      end
      B_START: begin
        if (baud_tick) begin
          cnt_d     = CNT_FULL;
          bit_cnt_d = 3'd0;
          bst_d     = rx_s_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      B_DATA: begin
        if (baud_tick) begin
          cnt_d     = CNT_FULL;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) bst_d = B_STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      B_STOP: begin
        if (baud_tick) begin
          bst_d = B_IDLE;
          if (rx_s_q) byte_rdy = 1'b1;
          else        stop_err = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: bst_d = B_IDLE;
    endcase
  end

  // Byte FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst_q     <= B_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      bst_q     <= bst_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // The shift register holds the complete byte during the stop-bit sample
  assign rx_byte = shift_q;

  // Packet FSM: header hunt, field staging, range check of hi bytes
  always_comb begin
    pst_d        = pst_q;
    pcnt_d       = pcnt_q;
    batt_st_d    = batt_st_q;
    curr_st_d    = curr_st_q;
    tq_hi_d      = tq_hi_q;
    batt_v_d     = batt_v_q;
    avg_curr_d   = avg_curr_q;
    avg_torque_d = avg_torque_q;
    vld_d        = 1'b0;
    frm_err_d    = stop_err;
    if (stop_err) begin
      pst_d = P_HDR1;
    end else if (byte_rdy) begin
      case (pst_q)
        P_HDR1: begin
          if (rx_byte == 8'hAA) pst_d = P_HDR2;
        end
        P_HDR2: begin
          if (rx_byte == 8'h55) begin
            pst_d  = P_DATA;
            pcnt_d = 3'd0;
          end else if (rx_byte != 8'hAA) begin
            pst_d = P_HDR1;
          end
        end
        P_DATA: begin
          pcnt_d = pcnt_q + 3'd1;
          // Even slots carry the 4-bit upper field; anything above it is corrupt
          if (!pcnt_q[0] && (rx_byte[7:4] != 4'h0)) begin
            frm_err_d = 1'b1;
            pst_d     = P_HDR1;
          end else begin
            case (pcnt_q)
              3'd0: batt_st_d[11:8] = rx_byte[3:0];
              3'd1: batt_st_d[7:0]  = rx_byte;
              3'd2: curr_st_d[11:8] = rx_byte[3:0];
              3'd3: curr_st_d[7:0]  = rx_byte;
              3'd4: tq_hi_d         = rx_byte[3:0];
              3'd5: begin
                batt_v_d     = batt_st_q;
                avg_curr_d   = curr_st_q;
                avg_torque_d = {tq_hi_q, rx_byte};
                vld_d        = 1'b1;
                pst_d        = P_HDR1;
              end
              default: pst_d = P_HDR1;
            endcase
          end
        end
        default: pst_d = P_HDR1;
      endcase
    end
  end

  // Packet FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pst_q        <= P_HDR1;
      pcnt_q       <= 3'd0;
      batt_st_q    <= 12'd0;
      curr_st_q    <= 12'd0;
      tq_hi_q      <= 4'd0;
      batt_v_q     <= 12'd0;
      avg_curr_q   <= 12'd0;
      avg_torque_q <= 12'd0;
      vld_q        <= 1'b0;
      frm_err_q    <= 1'b0;
    end else begin
      pst_q        <= pst_d;
      pcnt_q       <= pcnt_d;
      batt_st_q    <= batt_st_d;
      curr_st_q    <= curr_st_d;
      tq_hi_q      <= tq_hi_d;
      batt_v_q     <= batt_v_d;
      avg_curr_q   <= avg_curr_d;
      avg_torque_q <= avg_torque_d;
      vld_q        <= vld_d;
      frm_err_q    <= frm_err_d;
    end
  end

  assign bus.batt_v     = batt_v_q;
  assign bus.avg_curr   = avg_curr_q;
  assign bus.avg_torque = avg_torque_q;
  assign bus.vld        = vld_q;
  assign bus.frm_err    = frm_err_q;

endmodule
`default_nettype wire
